// File: rtl/regbank_pkg.sv
// Shared widths, writeback request struct and grant encoding for the
// register-bank writeback arbiter.
package regbank_pkg;

  localparam int AWIDTH = 5;
  localparam int DWIDTH = 32;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } wb_gnt_e;

endpackage

// File: rtl/regbank_wb_prio.sv
// Grant decode for the writeback port: LSU has priority, and starve_cnt
// forces an ALU win after STARVE_LIMIT consecutive ALU losses.
module regbank_wb_prio
  import regbank_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    alu_valid,
  input  logic    lsu_valid,
  output wb_gnt_e gnt
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  always_comb begin
    gnt = GNT_NONE;
    if (alu_valid && lsu_valid) begin
      gnt = (starve_cnt == LIMIT) ? GNT_ALU : GNT_LSU;
    end else if (alu_valid) begin
      gnt = GNT_ALU;
    end else if (lsu_valid) begin
      gnt = GNT_LSU;
    end
  end

  // Counts only contested LSU wins; any ALU grant or idle ALU clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (alu_valid && lsu_valid && gnt == GNT_LSU) begin
      starve_cnt <= starve_cnt + CW'(1);
    end else if (gnt == GNT_ALU || !alu_valid) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Two-requester (ALU/LSU) writeback arbiter feeding the register bank through
// a registered write port. Optional read bypass enabled by REGBANK_WB_FWD_EN.
// Handshake: a request transfers in the cycle where valid && ready; ready is
// combinational, requesters hold valid/addr/data stable until accepted.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int AWIDTH       = regbank_pkg::AWIDTH,
  parameter int DWIDTH       = regbank_pkg::DWIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AWIDTH-1:0] alu_waddr,
  input  logic [DWIDTH-1:0] alu_wdata,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [AWIDTH-1:0] lsu_waddr,
  input  logic [DWIDTH-1:0] lsu_wdata,
  output logic              rb_wen,
  output logic [AWIDTH-1:0] rb_waddr,
  output logic [DWIDTH-1:0] rb_wdata
`ifdef REGBANK_WB_FWD_EN
  ,
  input  logic [AWIDTH-1:0] fwd_raddr1,
  input  logic [AWIDTH-1:0] fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DWIDTH-1:0] fwd_data1,
  output logic [DWIDTH-1:0] fwd_data2
`endif
);

  wb_gnt_e           gnt;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;

  regbank_wb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .lsu_valid(lsu_valid),
    .gnt      (gnt)
  );

  assign alu_ready = (gnt == GNT_ALU);
  assign lsu_ready = (gnt == GNT_LSU);
  assign sel_addr  = (gnt == GNT_LSU) ? lsu_waddr : alu_waddr;
  assign sel_data  = (gnt == GNT_LSU) ? lsu_wdata : alu_wdata;

  // x0 writes are accepted but never reach the bank; addr/data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_wen   <= 1'b0;
      rb_waddr <= '0;
      rb_wdata <= '0;
    end else if (gnt != GNT_NONE && sel_addr != '0) begin
      rb_wen   <= 1'b1;
      rb_waddr <= sel_addr;
      rb_wdata <= sel_data;
    end else begin
      rb_wen   <= 1'b0;
    end
  end

`ifdef REGBANK_WB_FWD_EN
  assign fwd_hit1  = rb_wen && (rb_waddr == fwd_raddr1) && (fwd_raddr1 != '0);
  assign fwd_hit2  = rb_wen && (rb_waddr == fwd_raddr2) && (fwd_raddr2 != '0);
  assign fwd_data1 = fwd_hit1 ? rb_wdata : '0;
  assign fwd_data2 = fwd_hit2 ? rb_wdata : '0;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter; forwarding cases run when
// REGBANK_WB_FWD_EN is defined.
module tb_regbank_wb_arbiter;
  import regbank_pkg::*;

  localparam int W = $bits(wb_req_t);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_waddr = '0;
  logic [31:0] alu_wdata = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        rb_wen;
  logic [4:0]  rb_waddr;
  logic [31:0] rb_wdata;
`ifdef REGBANK_WB_FWD_EN
  logic [4:0]  fwd_raddr1 = '0;
  logic [4:0]  fwd_raddr2 = '0;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  regbank_wb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_waddr(alu_waddr),
    .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_waddr(lsu_waddr),
    .lsu_wdata(lsu_wdata),
    .rb_wen   (rb_wen),
    .rb_waddr (rb_waddr),
    .rb_wdata (rb_wdata)
`ifdef REGBANK_WB_FWD_EN
    ,
    .fwd_raddr1(fwd_raddr1),
    .fwd_raddr2(fwd_raddr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; hand-computed readies decide what the bank must see.
  task automatic step(input string name,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic e_ar, input logic e_lr);
    wb_req_t r;
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    @(negedge clk);
    check({name, "_alu_ready"}, {63'd0, alu_ready}, {63'd0, e_ar});
    check({name, "_lsu_ready"}, {63'd0, lsu_ready}, {63'd0, e_lr});
    if (av && e_ar && aa != 5'd0) begin
      r.addr = aa; r.data = ad; exp_q.push_back(r);
    end
    if (lv && e_lr && la != 5'd0) begin
      r.addr = la; r.data = ld; exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  // scoreboard monitor: every bank write must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && rb_wen) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write", rb_waddr, rb_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({rb_waddr, rb_wdata} !== e) begin
          n_fail++;
          $display("FAIL bank_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   rb_waddr, rb_wdata, e[W-1:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    check("reset_wen", {63'd0, rb_wen}, 64'd0);
    check("reset_waddr", {59'd0, rb_waddr}, 64'd0);
    check("reset_wdata", {32'd0, rb_wdata}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: reset while a write is landing
    step("t1_lsu", 0, 0, 0, 1, 5'd3, 32'hAA, 0, 1);
    check("t1_inflight_wen", {63'd0, rb_wen}, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t1_rst_wen", {63'd0, rb_wen}, 64'd0);
    check("t1_rst_waddr", {59'd0, rb_waddr}, 64'd0);
    check("t1_rst_wdata", {32'd0, rb_wdata}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 2: single requester, then idle hold
    step("t2_alu", 1, 5'd5, 32'h1234, 0, 0, 0, 1, 0);
    step("t2_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_idle_wen", {63'd0, rb_wen}, 64'd0);
    check("t2_hold_waddr", {59'd0, rb_waddr}, 64'd5);
    check("t2_hold_wdata", {32'd0, rb_wdata}, 64'h1234);

    // 3: starvation, grants LSU x4, ALU, LSU; then ALU alone
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ad;
      logic [31:0] ld;
      logic [4:0]  la;
      ad = (i < 5) ? 32'hA0 : 32'hA1;
      la = (i < 5) ? 5'(10 + i) : 5'd14;
      ld = (i < 5) ? 32'h100 + 32'(i) : 32'h104;
      if (i == 4) begin
        la = 5'd14; ld = 32'h104;
      end
      step($sformatf("t3_both%0d", i), 1, 5'd6, ad, 1, la, ld, i == 4, i != 4);
    end
    step("t3_alu_alone", 1, 5'd6, 32'hA1, 0, 0, 0, 1, 0);

    // 4: x0 write is accepted and dropped
    step("t4_lsu_x0", 0, 0, 0, 1, 5'd0, 32'hFF, 0, 1);
    check("t4_x0_wen", {63'd0, rb_wen}, 64'd0);
    check("t4_x0_hold_waddr", {59'd0, rb_waddr}, 64'd6);
    check("t4_x0_hold_wdata", {32'd0, rb_wdata}, 64'hA1);
    step("t4_alu", 1, 5'd1, 32'd7, 0, 0, 0, 1, 0);
    check("t4_alu_wen", {63'd0, rb_wen}, 64'd1);
    check("t4_alu_waddr", {59'd0, rb_waddr}, 64'd1);

    // 5: same-address collision, LSU lands first
    step("t5_both", 1, 5'd9, 32'h11, 1, 5'd9, 32'h22, 0, 1);
    step("t5_alu", 1, 5'd9, 32'h11, 0, 0, 0, 1, 0);

`ifdef REGBANK_WB_FWD_EN
    // 6: forwarding of the landing write
    step("t6_lsu", 0, 0, 0, 1, 5'd4, 32'h55, 0, 1);
    fwd_raddr1 = 5'd4; fwd_raddr2 = 5'd0;
    #1;
    check("t6_hit1", {63'd0, fwd_hit1}, 64'd1);
    check("t6_data1", {32'd0, fwd_data1}, 64'h55);
    check("t6_hit2", {63'd0, fwd_hit2}, 64'd0);
    check("t6_data2", {32'd0, fwd_data2}, 64'd0);
    fwd_raddr1 = 5'd3; fwd_raddr2 = 5'd4;
    #1;
    check("t6_miss1", {63'd0, fwd_hit1}, 64'd0);
    check("t6_hit2b", {63'd0, fwd_hit2}, 64'd1);
    check("t6_data2b", {32'd0, fwd_data2}, 64'h55);
`endif

    step("drain0", 0, 0, 0, 0, 0, 0, 0, 0);
    step("drain1", 0, 0, 0, 0, 0, 0, 0, 0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
